// File: rtl/fu_mem_sched.sv
// Memory functional-unit scheduler: arbitrates load/store requesters onto one memory FU.
// Define FU_MEM_SCHED_RR_EN for round-robin arbitration (default: load over store).
module fu_mem_sched #(
  parameter int LATENCY = 3,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_req,
  input  logic             st_req,
  input  logic [TAG_W-1:0] ld_tag,
  input  logic [TAG_W-1:0] st_tag,
  input  logic [31:0]      ld_rs1,
  input  logic [31:0]      ld_imm,
  input  logic [31:0]      st_rs1,
  input  logic [31:0]      st_rs2,
  input  logic [31:0]      st_imm,
  input  logic [2:0]       ld_bhw,
  input  logic [2:0]       st_bhw,
  output logic             ld_gnt,
  output logic             st_gnt,
  output logic             fu_en,
  output logic             fu_mem_w,
  output logic [2:0]       fu_bhw,
  output logic [31:0]      fu_rs1,
  output logic [31:0]      fu_rs2,
  output logic [31:0]      fu_imm,
  input  logic [31:0]      fu_data,
  output logic             cdb_valid,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_data,
  input  logic             cdb_ack,
  output logic             st_done,
  output logic             busy
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAT_C  = CW'(LATENCY);
  localparam logic [CW-1:0] WAIT_C = CW'(LATENCY - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam bit LAT1 = (LATENCY == 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, RESULT, DRAIN
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [TAG_W-1:0] tag_q;
  logic pick_ld, grant, done_wait;

`ifdef FU_MEM_SCHED_RR_EN
  logic prio_ld;
  assign pick_ld = ld_req && (!st_req || prio_ld);
`else
  assign pick_ld = ld_req;
`endif

  assign grant  = (state == IDLE) && !rst && (ld_req || st_req);
  assign ld_gnt = grant && pick_ld;
  assign st_gnt = grant && !pick_ld;

  // Last cycle the FU result may be sampled; with LATENCY=1 that is ISSUE itself.
  assign done_wait = (state == WAIT && cnt == ONE_C) ||
                     (state == ISSUE && LAT1);

  assign fu_en     = (state == ISSUE);
  assign cdb_valid = (state == RESULT);
  assign busy      = (state != IDLE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (ld_req || st_req) state_n = ISSUE;
      ISSUE:  if (!LAT1) state_n = WAIT;
              else state_n = fu_mem_w ? IDLE : RESULT;
      WAIT:   if (cnt == ONE_C) state_n = fu_mem_w ? IDLE : RESULT;
      RESULT: if (cdb_ack) state_n = IDLE;
      DRAIN:  if (cnt == ONE_C) state_n = IDLE;
      default: state_n = DRAIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DRAIN;
      cnt      <= LAT_C;
      st_done  <= 1'b0;
      cdb_tag  <= '0;
      cdb_data <= '0;
    end else begin
      state   <= state_n;
      st_done <= done_wait && fu_mem_w;
      if (state == ISSUE) cnt <= WAIT_C;
      else if (state == WAIT || state == DRAIN) cnt <= cnt - ONE_C;
      if (done_wait && !fu_mem_w) begin
        cdb_tag  <= tag_q;
        cdb_data <= fu_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fu_mem_w <= 1'b0;
      fu_bhw   <= '0;
      fu_rs1   <= '0;
      fu_rs2   <= '0;
      fu_imm   <= '0;
      tag_q    <= '0;
    end else if (grant) begin
      fu_mem_w <= !pick_ld;
      fu_bhw   <= pick_ld ? ld_bhw : st_bhw;
      fu_rs1   <= pick_ld ? ld_rs1 : st_rs1;
      fu_rs2   <= pick_ld ? 32'd0  : st_rs2;
      fu_imm   <= pick_ld ? ld_imm : st_imm;
      tag_q    <= pick_ld ? ld_tag : st_tag;
    end
  end

`ifdef FU_MEM_SCHED_RR_EN
  always_ff @(posedge clk) begin
    if (rst) prio_ld <= 1'b1;
    else if (grant) prio_ld <= !pick_ld;
  end
`endif

endmodule

// File: tb/tb_fu_mem_sched.sv
// Bench for fu_mem_sched: directed scenarios then random traffic against a
// transaction-timeline reference model.
module tb_fu_mem_sched;
  localparam int LAT = 3;
  localparam int TW  = 5;

  logic clk = 0;
  logic rst, ld_req, st_req, cdb_ack;
  logic [TW-1:0] ld_tag, st_tag, cdb_tag;
  logic [31:0] ld_rs1, ld_imm, st_rs1, st_rs2, st_imm;
  logic [2:0] ld_bhw, st_bhw, fu_bhw;
  logic ld_gnt, st_gnt, fu_en, fu_mem_w, cdb_valid, st_done, busy;
  logic [31:0] fu_rs1, fu_rs2, fu_imm, fu_data, cdb_data;

  fu_mem_sched #(.LATENCY(LAT), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .ld_req(ld_req), .st_req(st_req),
    .ld_tag(ld_tag), .st_tag(st_tag), .ld_rs1(ld_rs1), .ld_imm(ld_imm),
    .st_rs1(st_rs1), .st_rs2(st_rs2), .st_imm(st_imm),
    .ld_bhw(ld_bhw), .st_bhw(st_bhw), .ld_gnt(ld_gnt), .st_gnt(st_gnt),
    .fu_en(fu_en), .fu_mem_w(fu_mem_w), .fu_bhw(fu_bhw), .fu_rs1(fu_rs1),
    .fu_rs2(fu_rs2), .fu_imm(fu_imm), .fu_data(fu_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_ack(cdb_ack), .st_done(st_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_run = 0, n_fail = 0, cyc = 0;

  // Reference model: one operation timeline (grant g, issue g+1, done g+1+LAT)
  bit op_act = 0, op_ld = 0, have_lat = 0, cdb_zero = 0, last_ld = 0;
  int issue_c = 0, idle_from = 0, st_done_c = -100;
  logic [TW-1:0] op_tag;
  logic [31:0] op_rs1, op_rs2, op_imm;
  logic [2:0] op_bhw;
  int fuen_c = -1, valid_c = -1, stdone_seen = -1, gnt_c = -1;
  bit prev_valid = 0;
  bit gnt_log[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic bit prefer_ld();
`ifdef FU_MEM_SCHED_RR_EN
    return !last_ld;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cyc=%0d",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    bit idle, gl, gs, res;
    if (op_act && op_ld && cyc == issue_c + LAT - 1)
      fu_data = word(op_rs1 + op_imm);
    else
      fu_data = $urandom;
    #1;
    if (rst) begin
      op_act = 0; have_lat = 0; last_ld = 0; cdb_zero = 1;
      idle_from = cyc + 1 + LAT; st_done_c = -100;
    end else begin
      idle = !op_act && cyc >= idle_from;
      gl = idle && ld_req && (!st_req || prefer_ld());
      gs = idle && st_req && !gl;
      res = op_act && op_ld && cyc >= issue_c + LAT;
      chk("ld_gnt", 32'(ld_gnt), 32'(gl));
      chk("st_gnt", 32'(st_gnt), 32'(gs));
      chk("busy", 32'(busy), 32'(!idle));
      chk("fu_en", 32'(fu_en), 32'(op_act && cyc == issue_c));
      chk("cdb_valid", 32'(cdb_valid), 32'(res));
      chk("st_done", 32'(st_done), 32'(cyc == st_done_c));
      if (have_lat) begin
        chk("fu_mem_w", 32'(fu_mem_w), 32'(!op_ld));
        chk("fu_rs1", fu_rs1, op_rs1);
        chk("fu_imm", fu_imm, op_imm);
        chk("fu_bhw", 32'(fu_bhw), 32'(op_bhw));
        if (!op_ld) chk("fu_rs2", fu_rs2, op_rs2);
      end
      if (res) begin
        chk("cdb_tag", 32'(cdb_tag), 32'(op_tag));
        chk("cdb_data", cdb_data, word(op_rs1 + op_imm));
        cdb_zero = 0;
      end else if (cdb_zero) begin
        chk("cdb_tag_rst", 32'(cdb_tag), 32'd0);
        chk("cdb_data_rst", cdb_data, 32'd0);
      end
      if (fu_en === 1'b1) fuen_c = cyc;
      if (cdb_valid === 1'b1 && !prev_valid) valid_c = cyc;
      if (st_done === 1'b1) stdone_seen = cyc;
      if (gl || gs) begin
        op_act = 1; op_ld = gl; have_lat = 1; issue_c = cyc + 1;
        last_ld = gl; gnt_c = cyc;
        gnt_log.push_back(gl);
        op_tag = gl ? ld_tag : st_tag;
        op_rs1 = gl ? ld_rs1 : st_rs1;
        op_imm = gl ? ld_imm : st_imm;
        op_rs2 = st_rs2;
        op_bhw = gl ? ld_bhw : st_bhw;
      end else if (op_act && !op_ld && cyc == issue_c + LAT - 1) begin
        op_act = 0; st_done_c = cyc + 1; idle_from = cyc + 1;
      end else if (res && cdb_ack) begin
        op_act = 0; idle_from = cyc + 1;
      end
    end
    prev_valid = (cdb_valid === 1'b1);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_ops();
    ld_tag = TW'($urandom); st_tag = TW'($urandom);
    ld_rs1 = $urandom; ld_imm = $urandom; st_rs1 = $urandom;
    st_rs2 = $urandom; st_imm = $urandom;
    ld_bhw = 3'($urandom); st_bhw = 3'($urandom);
  endtask

  initial begin
    int rst_c;
    rst = 1; ld_req = 0; st_req = 0; cdb_ack = 1;
    rand_ops();
    @(negedge clk);
    run(2);
    rst = 0;
    run(LAT + 2);

    // Single load at 0x10+4, tag 3
    ld_req = 1; ld_rs1 = 32'h10; ld_imm = 32'h4; ld_tag = 3;
    step();
    ld_req = 0;
    run(LAT + 3);
    chk("load_lat", 32'(valid_c - fuen_c), 32'(LAT));

    // Single store
    st_req = 1; st_rs2 = 32'hDEADBEEF;
    step();
    st_req = 0;
    run(LAT + 3);
    chk("store_lat", 32'(stdone_seen - fuen_c), 32'(LAT));

    // Contention over four operations
    gnt_log.delete();
    ld_req = 1; st_req = 1;
    run(4 * (LAT + 2) + 1);
    ld_req = 0; st_req = 0;
    run(LAT + 3);
    chk("cont_count", 32'(gnt_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
`ifdef FU_MEM_SCHED_RR_EN
      chk("cont_order", 32'(gnt_log[i]), 32'(i % 2 == 0));
`else
      chk("cont_order", 32'(gnt_log[i]), 32'd1);
`endif

    // CDB backpressure with a competing store
    ld_req = 1; cdb_ack = 0;
    step();
    ld_req = 0; st_req = 1;
    run(LAT + 5);
    cdb_ack = 1;
    run(3);
    chk("bp_regrant", 32'(gnt_c - (cyc - 3)), 32'd1);
    st_req = 0;
    run(LAT + 3);

    // Reset during WAIT, load still pending afterwards
    ld_req = 1;
    step();
    step();
    rst = 1; rst_c = cyc;
    step();
    rst = 0;
    run(LAT + 2);
    chk("rst_regrant", 32'(gnt_c - rst_c), 32'(LAT + 1));
    ld_req = 0;
    run(LAT + 3);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      rand_ops();
      ld_req  = ($urandom_range(0, 2) != 0);
      st_req  = ($urandom_range(0, 2) != 0);
      cdb_ack = $urandom_range(0, 1);
      rst     = ($urandom_range(0, 79) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
